// File: rtl/fetch_decode_if.sv
// Decoded-op handshake between fetch_decode (master) and the execute stage (slave).
interface fetch_decode_if;
  logic       valid;
  logic       ready;
  logic       op_add;
  logic       op_nand;
  logic       op_push;
  logic [1:0] rd;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [3:0] imm;

  modport master (
    output valid, op_add, op_nand, op_push, rd, ra, rb, imm,
    input  ready
  );

  modport slave (
    input  valid, op_add, op_nand, op_push, rd, ra, rb, imm,
    output ready
  );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode stage of the 4-bit CPU: owns the PC, drives the ROM address, decodes the
// returned instruction and hands registered ops to execute over valid/ready.
// Optional feature macro: FETCH_DECODE_JUMP_EN (op 100 becomes JUMP imm instead of illegal).
module fetch_decode #(
  parameter logic [3:0] RESET_PC   = 4'd0,
  parameter bit         AUTO_START = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  output logic [3:0]     o_pc,
  input  logic [8:0]     i_ins,
  fetch_decode_if.master o_dec,
  output logic           o_halted,
  output logic           o_illegal
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e     r_state;
  logic [3:0] r_pc;
  logic       r_valid;
  logic       r_op_add;
  logic       r_op_nand;
  logic       r_op_push;
  logic [1:0] r_rd;
  logic [1:0] r_ra;
  logic [1:0] r_rb;
  logic [3:0] r_imm;
  logic       r_halted;
  logic       r_illegal;

  logic [2:0] w_opcode;
  logic       w_adv;
  logic       w_is_op;

  assign w_opcode = i_ins[8:6];
  // A held op blocks the pipeline until execute takes it.
  assign w_adv    = !r_valid || o_dec.ready;
  assign w_is_op  = (w_opcode == 3'b000) || (w_opcode == 3'b001) || (w_opcode == 3'b010);

  // State machine, PC and all registered decode outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= AUTO_START ? StRun : StIdle;
      r_pc      <= RESET_PC;
      r_valid   <= 1'b0;
      r_op_add  <= 1'b0;
      r_op_nand <= 1'b0;
      r_op_push <= 1'b0;
      r_rd      <= 2'd0;
      r_ra      <= 2'd0;
      r_rb      <= 2'd0;
      r_imm     <= 4'd0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) r_state <= StRun;
        end
        StRun: begin
          if (w_adv) begin
            // Bubble by default; only real ops raise valid.
            r_valid   <= 1'b0;
            r_op_add  <= 1'b0;
            r_op_nand <= 1'b0;
            r_op_push <= 1'b0;
            if (w_is_op) begin
              r_rd  <= i_ins[5:4];
              r_ra  <= i_ins[3:2];
              r_rb  <= i_ins[1:0];
              r_imm <= i_ins[3:0];
            end
            unique case (w_opcode)
              3'b000: begin
                r_valid  <= 1'b1;
                r_op_add <= 1'b1;
                r_pc     <= r_pc + 4'd1;
              end
              3'b001: begin
                r_valid   <= 1'b1;
                r_op_nand <= 1'b1;
                r_pc      <= r_pc + 4'd1;
              end
              3'b010: begin
                r_valid   <= 1'b1;
                r_op_push <= 1'b1;
                r_pc      <= r_pc + 4'd1;
              end
              3'b011: r_pc <= r_pc + 4'd1;
              3'b110: begin
                r_state  <= StHalt;
                r_halted <= 1'b1;
              end
`ifdef FETCH_DECODE_JUMP_EN
              3'b100: r_pc <= i_ins[3:0];
`endif
              default: begin
                r_state   <= StHalt;
                r_halted  <= 1'b1;
                r_illegal <= 1'b1;
              end
            endcase
          end
        end
        StHalt: begin
          // Frozen until reset.
        end
        default: r_state <= StHalt;
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_halted      = r_halted;
  assign o_illegal     = r_illegal;
  assign o_dec.valid   = r_valid;
  assign o_dec.op_add  = r_op_add;
  assign o_dec.op_nand = r_op_nand;
  assign o_dec.op_push = r_op_push;
  assign o_dec.rd      = r_rd;
  assign o_dec.ra      = r_ra;
  assign o_dec.rb      = r_rb;
  assign o_dec.imm     = r_imm;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with a scoreboard of expected transfers.
module tb_fetch_decode;

  localparam logic [8:0] Noop = 9'b011000000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pc, pc_w;
  logic [8:0] ins, ins_w;
  logic       halted, illegal, halted_w, illegal_w;
  logic [8:0] rom   [16];
  logic [8:0] rom_w [16];

  int errors = 0;
  int checks = 0;
  logic [12:0] sb_q[$];

  fetch_decode_if bus ();
  fetch_decode_if bus_w ();

  assign ins = rom[pc];
  assign ins_w = rom_w[pc_w];
  assign bus_w.ready = 1'b1;

  fetch_decode #(.RESET_PC(4'h0), .AUTO_START(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_pc(pc), .i_ins(ins),
    .o_dec(bus), .o_halted(halted), .o_illegal(illegal)
  );

  fetch_decode #(.RESET_PC(4'hE), .AUTO_START(1'b1)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_start(1'b0), .o_pc(pc_w), .i_ins(ins_w),
    .o_dec(bus_w), .o_halted(halted_w), .o_illegal(illegal_w)
  );

  always #5 clk = ~clk;

  // Expected {add,nand,push,rd,ra,rb,imm} for a valid op word.
  function automatic logic [12:0] exp_of(input logic [8:0] w);
    logic [2:0] ops;
    case (w[8:6])
      3'b000:  ops = 3'b100;
      3'b001:  ops = 3'b010;
      default: ops = 3'b001;
    endcase
    return {ops, w[5:4], w[3:2], w[1:0], w[3:0]};
  endfunction

  function automatic logic [12:0] pack_bus();
    return {bus.op_add, bus.op_nand, bus.op_push, bus.rd, bus.ra, bus.rb, bus.imm};
  endfunction

  function automatic logic [12:0] pack_bus_w();
    return {bus_w.op_add, bus_w.op_nand, bus_w.op_push, bus_w.rd, bus_w.ra, bus_w.rb,
            bus_w.imm};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; any transfer seen at the edge is scored against the queue head.
  task automatic step();
    logic        xfer;
    logic [12:0] got;
    logic [12:0] exp;
    xfer = bus.valid && bus.ready && !rst;
    got  = pack_bus();
    @(posedge clk);
    #1;
    if (xfer) begin
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 13'h1FFF;
      check("sb_xfer", 16'(got), 16'(exp));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rom[i] = Noop;
      rom_w[i] = Noop;
    end
    rom[0] = 9'b010000110;  // PUSH r0,6
    rom[1] = 9'b010111001;  // PUSH r3,9
    rom[2] = 9'b000100001;  // ADD r2,r0,r1
    rom[3] = Noop;
    rom[4] = 9'b000111001;  // ADD r3,r2,r1
    rom[5] = 9'b001010110;  // NAND r1,r1,r2
    rom[6] = 9'b110000000;  // HALT
    rom_w[0] = 9'b010000110;

    step();
    step();
    check("rst_pc", 16'(pc), 16'h0);
    check("rst_valid", 16'(bus.valid), 16'h0);
    check("rst_halted", 16'(halted), 16'h0);
    check("rst_illegal", 16'(illegal), 16'h0);
    check("rst_pc_w", 16'(pc_w), 16'hE);

    sb_q.push_back(exp_of(rom[0]));
    sb_q.push_back(exp_of(rom[1]));
    sb_q.push_back(exp_of(rom[2]));
    sb_q.push_back(exp_of(rom[4]));
    sb_q.push_back(exp_of(rom[5]));

    rst = 1'b0;
    start = 1'b1;
    bus.ready = 1'b1;
    step();
    start = 1'b0;
    check("idle_to_run_pc", 16'(pc), 16'h0);
    check("idle_to_run_valid", 16'(bus.valid), 16'h0);
    check("wrap_pc_f", 16'(pc_w), 16'hF);

    step();
    check("push_pc", 16'(pc), 16'h1);
    check("push_valid", 16'(bus.valid), 16'h1);
    check("push_dec", 16'(pack_bus()), 16'(exp_of(rom[0])));
    check("wrap_pc_0", 16'(pc_w), 16'h0);

    step();
    check("push2_pc", 16'(pc), 16'h2);
    check("push2_dec", 16'(pack_bus()), 16'(exp_of(rom[1])));
    check("wrap_pc_1", 16'(pc_w), 16'h1);
    check("wrap_valid", 16'(bus_w.valid), 16'h1);
    check("wrap_dec", 16'(pack_bus_w()), 16'(exp_of(rom_w[0])));

    step();
    check("add_pc", 16'(pc), 16'h3);
    check("add_dec", 16'(pack_bus()), 16'(exp_of(rom[2])));

    step();
    check("noop_pc", 16'(pc), 16'h4);
    check("noop_valid", 16'(bus.valid), 16'h0);

    step();
    check("add2_pc", 16'(pc), 16'h5);
    check("add2_valid", 16'(bus.valid), 16'h1);

    bus.ready = 1'b0;
    repeat (3) begin
      step();
      check("stall_pc", 16'(pc), 16'h5);
      check("stall_valid", 16'(bus.valid), 16'h1);
      check("stall_dec", 16'(pack_bus()), 16'(exp_of(rom[4])));
    end
    bus.ready = 1'b1;

    step();
    check("nand_pc", 16'(pc), 16'h6);
    check("nand_valid", 16'(bus.valid), 16'h1);
    check("nand_dec", 16'(pack_bus()), 16'(exp_of(rom[5])));

    step();
    check("halt_valid", 16'(bus.valid), 16'h0);
    check("halt_ops", 16'({bus.op_add, bus.op_nand, bus.op_push}), 16'h0);
    check("halt_pc", 16'(pc), 16'h6);
    check("halt_halted", 16'(halted), 16'h1);
    check("halt_illegal", 16'(illegal), 16'h0);

    start = 1'b1;
    step();
    step();
    start = 1'b0;
    check("halt_start_pc", 16'(pc), 16'h6);
    check("halt_start_halted", 16'(halted), 16'h1);
    check("halt_start_valid", 16'(bus.valid), 16'h0);
    check("sb_drained", 16'(sb_q.size()), 16'h0);

    // Reset out of HALT, then an illegal opcode.
    rst = 1'b1;
    sb_q.delete();
    step();
    check("rst_halt_pc", 16'(pc), 16'h0);
    check("rst_halt_halted", 16'(halted), 16'h0);
    check("rst_halt_illegal", 16'(illegal), 16'h0);
    rom[0] = 9'b111111110;
    rst = 1'b0;
    step();
    check("idle_hold_pc", 16'(pc), 16'h0);
    check("idle_hold_halted", 16'(halted), 16'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("ill_halted", 16'(halted), 16'h1);
    check("ill_illegal", 16'(illegal), 16'h1);
    check("ill_pc", 16'(pc), 16'h0);
    check("ill_valid", 16'(bus.valid), 16'h0);
    step();
    check("ill_sticky", 16'(illegal), 16'h1);

    // Op 100 at PC 8.
    rst = 1'b1;
    step();
    check("rst_ill_clear", 16'(illegal), 16'h0);
    for (int i = 0; i < 16; i++) rom[i] = Noop;
    rom[8] = 9'b100000101;
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    check("pre_jump_pc", 16'(pc), 16'h8);
    step();
`ifdef FETCH_DECODE_JUMP_EN
    check("jump_pc", 16'(pc), 16'h5);
    check("jump_valid", 16'(bus.valid), 16'h0);
    check("jump_halted", 16'(halted), 16'h0);
    check("jump_illegal", 16'(illegal), 16'h0);
    step();
    check("jump_next_pc", 16'(pc), 16'h6);
`else
    check("op100_halted", 16'(halted), 16'h1);
    check("op100_illegal", 16'(illegal), 16'h1);
    check("op100_pc", 16'(pc), 16'h8);
    check("op100_valid", 16'(bus.valid), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Instruction-side consumer of the 9-bit instruction ROM in the 4-bit CPU.
- Owns the program counter and drives it as the ROM address. Takes the combinational instruction back in the same cycle, decodes it and registers the decoded fields.
- Presents decoded ops to the execute/register-file stage over a valid/ready handshake.
- Handles noop, halt and illegal opcodes locally.

Parameters:
- RESET_PC, 4'd0, PC value loaded on RST.
- AUTO_START, 0, 1 = enter RUN directly out of reset; 0 = wait in IDLE for START.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- START  in  1  leaves IDLE (pulse or level)
- PC  out  4  program counter, ROM address
- INS  in  9  instruction from ROM for the current PC (combinational, valid within the cycle)
- OUT_VALID  out  1  decoded op held on outputs
- OUT_READY  in  1  execute stage accepts op this cycle
- OP_ADD  out  1  one-hot decoded op
- OP_NAND  out  1  one-hot decoded op
- OP_PUSH  out  1  one-hot decoded op
- RD  out  2  destination register, INS[5:4]
- RA  out  2  source A, INS[3:2]
- RB  out  2  source B, INS[1:0]
- IMM  out  4  immediate, INS[3:0]
- HALTED  out  1  state == HALT
- ILLEGAL  out  1  sticky; set when an illegal opcode is fetched

Behaviour:
- Interface: one clock CLK; reset RST is synchronous, active-high. All outputs are registered.
- Reset values:
  - PC = RESET_PC.
  - OUT_VALID, OP_*, RD, RA, RB, IMM, HALTED and ILLEGAL all 0.
  - State = RUN if AUTO_START else IDLE.
  - RST has priority over all inputs, including mid-handshake; a pending op is dropped.
- Instruction format: op = INS[8:6].
  - 000 ADD rd,ra,rb
  - 001 NAND rd,ra,rb
  - 010 PUSH rd,imm
  - 011 NOOP
  - 110 HALT
  - 100, 101, 111 illegal (100 is JUMP only with the optional feature).
- States:
  - IDLE: PC held, no fetch. START=1 moves to RUN on the next edge.
  - RUN: fetch/decode active.
  - HALT: no fetch, PC frozen. Exit only via RST.
- Advance condition in RUN: adv = !OUT_VALID || OUT_READY. When adv=0, PC and all output registers hold (stall).
- On an adv edge in RUN, registers are loaded from INS at the current PC:
  - ADD/NAND/PUSH: OUT_VALID<=1; the matching OP_* <=1 and the others <=0; RD/RA/RB/IMM <= fields; PC<=PC+1.
  - NOOP: OUT_VALID<=0 (bubble); PC<=PC+1.
  - HALT: OUT_VALID<=0; PC holds; state<=HALT.
  - Illegal: same as HALT, plus ILLEGAL<=1.
- Latency: the instruction at PC=n is on the outputs with OUT_VALID=1 one cycle after PC=n is driven, given no stall. Throughput is 1 op/cycle with OUT_READY held high.
- Handshake: a transfer occurs on an edge with OUT_VALID && OUT_READY. OUT_VALID, once high, stays high and the outputs stay stable until the transfer. OUT_READY while OUT_VALID=0 is ignored.
- PC wrap-around: 4'hF+1 = 4'h0 (modulo 16); no flag.
- Simultaneous transfer and fetch: when OUT_VALID && OUT_READY in RUN, the next op loads in the same edge, with no bubble.
- HALT drain: on entering HALT, an op already accepted is complete. OUT_VALID is 0 in HALT, because the halting fetch itself loads OUT_VALID<=0.
- START is ignored in RUN and HALT.
- Output fields when OUT_VALID=0: OP_* are 0. RD/RA/RB/IMM hold their last value and are don't-care.

Optional Feature:
- Macro: FETCH_DECODE_JUMP_EN.
- Defined: op 100 is JUMP imm.
  - On an adv edge: PC<=INS[3:0], OUT_VALID<=0 (one bubble), ILLEGAL unchanged.
  - A jump to its own address loops forever with no output.
- Undefined: op 100 is illegal and takes the HALT path with ILLEGAL<=1.

Test Plan:
- Basic decode: RST, AUTO_START=0, START pulse, ROM PC0=9'b010000110, OUT_READY=1 -> one cycle after PC=0: OUT_VALID=1, OP_PUSH=1, RD=0, IMM=4'b0110, PC=1.
- ADD then NOOP: PC2=9'b000100001, PC3=9'b011000000 -> OP_ADD=1, RD=2, RA=0, RB=1; next cycle OUT_VALID=0 while PC goes 3->4->5.
- Stall: OUT_READY=0 for 3 cycles while an ADD is valid -> PC and all outputs frozen. OUT_READY=1 -> transfer, and the next op (NAND 9'b001010110: RD=1, RA=1, RB=2) loads on the same edge.
- Wrap: RESET_PC=4'hE, all ROM words NOOP except 4'h0=PUSH -> PC sequence E,F,0, and the PUSH is presented after wrap.
- Halt/illegal: fetch 9'b110000000 -> HALTED=1, ILLEGAL=0, PC frozen. Reset, then fetch 9'b111111110 -> HALTED=1, ILLEGAL=1. START ignored; RST mid-HALT -> PC=RESET_PC, all flags 0.
- JUMP (macro on): fetch 9'b100000101 at PC=8 -> OUT_VALID=0 for one cycle, PC=5 next. Macro off: same word -> HALTED=1, ILLEGAL=1.
